// File: rtl/updown_disp_pkg.sv
// Shared types and constants for the up/down counter display stage.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package updown_disp_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ONES = 2'd1,
        S_TENS = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [3:0] COUNT_MAX = 4'd15;
    localparam logic [3:0] COUNT_MIN = 4'd0;
    localparam logic [3:0] DEC_BASE  = 4'd10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Non-decimal inputs (10..15) produce a dark digit.
module seg7_decode
    import updown_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (digit)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_count_display.sv
// Two-digit multiplexed display of a 4-bit up/down count, with a decimal point
// for down-count mode and a stretched LED flagging counter wrap-around.
//
// state  | meaning
// S_OFF  | after reset, both digits dark until the first refresh tick
// S_ONES | ones digit lit, decimal point shows down-count mode
// S_TENS | tens digit lit (blanked for values below 10 when enabled)
module updown_count_display
    import updown_disp_pkg::*;
#(
    parameter int REFRESH_DIV        = 50000,
    parameter int STRETCH_CYCLES     = 5000000,
    parameter int BLANK_LEADING_ZERO = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       dir_in,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       dp_n,
    output logic       wrap_led
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(REFRESH_DIV - 1);
    localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_CYCLES);

    logic [3:0]       cur_q;
    logic [3:0]       prev_q;
    logic             dir_q;
    logic [1:0]       valid_sr;
    logic             prev_valid;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    disp_state_t      state_q;
    disp_state_t      state_d;

    logic             tens;
    logic [3:0]       ones;
    logic [6:0]       ones_seg;
    logic [6:0]       tens_seg;

    logic [6:0]       seg_d;
    logic [1:0]       an_d;
    logic             dp_d;

    logic             wrap_up;
    logic             wrap_down;
    logic             wrap;
    logic [STR_W-1:0] stretch_cnt;

    // Input stage; prev_q only becomes meaningful once two real samples exist.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q    <= '0;
            prev_q   <= '0;
            dir_q    <= 1'b0;
            valid_sr <= 2'b00;
        end else begin
            cur_q    <= count_in;
            prev_q   <= cur_q;
            dir_q    <= dir_in;
            valid_sr <= {valid_sr[0], 1'b1};
        end
    end

    assign prev_valid = valid_sr[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    assign tens = (cur_q >= DEC_BASE);
    assign ones = tens ? (cur_q - DEC_BASE) : cur_q;

    seg7_decode u_dec_ones (
        .digit (ones),
        .seg_n (ones_seg)
    );

    seg7_decode u_dec_tens (
        .digit ({3'b000, tens}),
        .seg_n (tens_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // The output registers double as the digit latch: they load only on a tick,
    // so the lit digit cannot change partway through its period.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_n;
        an_d    = an_n;
        dp_d    = dp_n;
        if (tick) begin
            case (state_q)
                S_OFF:   state_d = S_ONES;
                S_ONES:  state_d = S_TENS;
                S_TENS:  state_d = S_ONES;
                default: state_d = S_OFF;
            endcase
            case (state_d)
                S_ONES: begin
                    an_d  = 2'b10;
                    seg_d = ones_seg;
                    dp_d  = ~dir_q;
                end
                S_TENS: begin
                    an_d  = 2'b01;
                    seg_d = (!tens && (BLANK_LEADING_ZERO != 0)) ? SEG_BLANK : tens_seg;
                    dp_d  = 1'b1;
                end
                default: begin
                    an_d  = 2'b11;
                    seg_d = SEG_BLANK;
                    dp_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n <= SEG_BLANK;
            an_n  <= 2'b11;
            dp_n  <= 1'b1;
        end else begin
            seg_n <= seg_d;
            an_n  <= an_d;
            dp_n  <= dp_d;
        end
    end

    // Only the two genuine wrap transitions count; other jumps (e.g. counter reset) are ignored.
    assign wrap_up   = !dir_q && (prev_q == COUNT_MAX) && (cur_q == COUNT_MIN);
    assign wrap_down =  dir_q && (prev_q == COUNT_MIN) && (cur_q == COUNT_MAX);
    assign wrap      = prev_valid && (wrap_up || wrap_down);

    always_ff @(posedge clk) begin
        if (reset) begin
            stretch_cnt <= '0;
        end else if (wrap) begin
            stretch_cnt <= STRETCH_LOAD;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - STR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_led <= 1'b0;
        end else begin
            wrap_led <= (stretch_cnt != '0);
        end
    end

endmodule

// File: tb/tb_updown_count_display.sv
// Directed bench for updown_count_display with a short refresh period and stretch.
// Display periods are table-driven; wrap/stretch/reset corners are hand sequences.
module tb_updown_count_display;

    localparam int REFRESH_DIV    = 4;
    localparam int STRETCH_CYCLES = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       dir_in;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       dp_n;
    logic       wrap_led;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [3:0] count;
        logic       dir;
        logic [6:0] seg;
        logic [1:0] an;
        logic       dp;
    } disp_vec_t;

    disp_vec_t vecs [14];

    updown_count_display #(
        .REFRESH_DIV        (REFRESH_DIV),
        .STRETCH_CYCLES     (STRETCH_CYCLES),
        .BLANK_LEADING_ZERO (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .dir_in   (dir_in),
        .seg_n    (seg_n),
        .an_n     (an_n),
        .dp_n     (dp_n),
        .wrap_led (wrap_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] c, input logic d, input logic exp_led, input string name);
        count_in = c;
        dir_in   = d;
        edge1();
        chk(name, {7'b0, wrap_led}, {7'b0, exp_led});
    endtask

    task automatic chk_disp(input string name, input logic [6:0] s, input logic [1:0] a, input logic p);
        chk({name, ".seg"}, {1'b0, seg_n}, {1'b0, s});
        chk({name, ".an"},  {6'b0, an_n},  {6'b0, a});
        chk({name, ".dp"},  {7'b0, dp_n},  {7'b0, p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] prev_seg;
        logic [1:0] prev_an;
        logic       prev_dp;

        // count, dir -> state entered at the period's tick and its outputs
        vecs[0]  = '{4'd12, 1'b1, 7'h79, 2'b01, 1'b1};
        vecs[1]  = '{4'd12, 1'b1, 7'h24, 2'b10, 1'b0};
        vecs[2]  = '{4'd5,  1'b0, 7'h7F, 2'b01, 1'b1};
        vecs[3]  = '{4'd5,  1'b0, 7'h12, 2'b10, 1'b1};
        vecs[4]  = '{4'd10, 1'b1, 7'h79, 2'b01, 1'b1};
        vecs[5]  = '{4'd10, 1'b1, 7'h40, 2'b10, 1'b0};
        vecs[6]  = '{4'd9,  1'b1, 7'h7F, 2'b01, 1'b1};
        vecs[7]  = '{4'd9,  1'b1, 7'h10, 2'b10, 1'b0};
        vecs[8]  = '{4'd15, 1'b0, 7'h79, 2'b01, 1'b1};
        vecs[9]  = '{4'd15, 1'b0, 7'h12, 2'b10, 1'b1};
        vecs[10] = '{4'd0,  1'b0, 7'h7F, 2'b01, 1'b1};
        vecs[11] = '{4'd0,  1'b0, 7'h40, 2'b10, 1'b1};
        vecs[12] = '{4'd8,  1'b1, 7'h7F, 2'b01, 1'b1};
        vecs[13] = '{4'd8,  1'b1, 7'h00, 2'b10, 1'b0};

        // Reset for 3 cycles
        reset    = 1'b1;
        count_in = 4'd7;
        dir_in   = 1'b0;
        repeat (3) edge1();
        chk_disp("reset", 7'h7F, 2'b11, 1'b1);
        chk("reset.led", {7'b0, wrap_led}, 8'h00);

        // Dark until the first tick (4th edge after release)
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            edge1();
            chk($sformatf("pre_tick%0d.an", i), {6'b0, an_n}, 8'h03);
        end
        edge1();
        chk_disp("seven_ones", 7'h78, 2'b10, 1'b1);
        repeat (4) edge1();
        chk_disp("seven_tens", 7'h7F, 2'b01, 1'b1);
        repeat (4) edge1();
        chk_disp("seven_ones2", 7'h78, 2'b10, 1'b1);

        // Table of digit periods: stable until the tick, then the new digit
        prev_seg = 7'h78;
        prev_an  = 2'b10;
        prev_dp  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            count_in = vecs[i].count;
            dir_in   = vecs[i].dir;
            repeat (3) edge1();
            chk_disp($sformatf("hold%0d", i), prev_seg, prev_an, prev_dp);
            edge1();
            chk_disp($sformatf("vec%0d", i), vecs[i].seg, vecs[i].an, vecs[i].dp);
            prev_seg = vecs[i].seg;
            prev_an  = vecs[i].an;
            prev_dp  = vecs[i].dp;
        end

        // Up-count wrap: 0 applied before E0, LED high from E2 through E9
        chk("idle.led", {7'b0, wrap_led}, 8'h00);
        step(4'd14, 1'b0, 1'b0, "up_14");
        step(4'd15, 1'b0, 1'b0, "up_15");
        step(4'd0,  1'b0, 1'b0, "up_e0");
        step(4'd1,  1'b0, 1'b0, "up_e1");
        for (int i = 2; i <= 9; i++) step(4'd1, 1'b0, 1'b1, $sformatf("up_e%0d", i));
        step(4'd1, 1'b0, 1'b0, "up_e10");

        // Down-count wrap, then a non-wrap 7->0, then a retrigger at E4
        step(4'd1,  1'b1, 1'b0, "dn_1");
        step(4'd0,  1'b1, 1'b0, "dn_0");
        step(4'd15, 1'b1, 1'b0, "dn_e0");
        step(4'd7,  1'b1, 1'b0, "dn_e1");
        step(4'd0,  1'b1, 1'b1, "dn_e2");
        step(4'd0,  1'b1, 1'b1, "dn_e3");
        step(4'd15, 1'b1, 1'b1, "dn_e4");
        step(4'd15, 1'b1, 1'b1, "dn_e5");
        for (int i = 6; i <= 13; i++) step(4'd15, 1'b1, 1'b1, $sformatf("retrig_e%0d", i));
        step(4'd15, 1'b1, 1'b0, "retrig_e14");

        // 15->7->0 in down mode is not a wrap
        step(4'd7, 1'b1, 1'b0, "nowrap_7");
        step(4'd0, 1'b1, 1'b0, "nowrap_0");
        step(4'd0, 1'b1, 1'b0, "nowrap_0b");

        // Reset mid-stretch
        step(4'd15, 1'b1, 1'b0, "rst_e0");
        step(4'd15, 1'b1, 1'b0, "rst_e1");
        step(4'd15, 1'b1, 1'b1, "rst_e2");
        step(4'd15, 1'b1, 1'b1, "rst_e3");
        reset = 1'b1;
        edge1();
        chk("mid_reset.led", {7'b0, wrap_led}, 8'h00);
        chk_disp("mid_reset", 7'h7F, 2'b11, 1'b1);
        edge1();
        reset = 1'b0;

        // Counter restarting at 15 after reset is not a wrap
        for (int i = 1; i <= 12; i++) step(4'd15, 1'b1, 1'b0, $sformatf("post_rst%0d", i));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
